// File: rtl/rr_arb_pkg.sv
// Shared limits and index helper for the N-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int N_MAX         = 32;
  localparam int MAX_BURST_MAX = 255;

  // (idx + 1) mod n without a divider; idx is always below n.
  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first-set: lowest set request at or above ptr, else lowest set request overall.
module rr_priority_pick #(
  parameter  int N    = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    requests_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic [IDXW-1:0] pick_idx_o,
  output logic            found_o
);

  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;
  logic            hi_found;
  logic            lo_found;

  // Descending scan so the last hit is the lowest index in each half.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (requests_i[i]) begin
        lo_idx   = IDXW'(i);
        lo_found = 1'b1;
        if (IDXW'(i) >= ptr_i) begin
          hi_idx   = IDXW'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    found_o    = lo_found;
    pick_idx_o = hi_found ? hi_idx : lo_idx;
    pick_o     = '0;
    for (int i = 0; i < N; i++) begin
      pick_o[i] = lo_found && (IDXW'(i) == pick_idx_o);
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with burst hold of up to MAX_BURST grants per owner.
// Define ROUND_ROBIN_ARB_OUT_REG_EN to register grants/grant_idx/grant_valid (1-cycle latency).
module round_robin_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int MAX_BURST = 1,
  localparam int IDXW      = $clog2(N),
  localparam int CNTW      = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    requests,
  output logic [N-1:0]    grants,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  if (N < 2 || N > N_MAX) begin : g_bad_n
    $error("round_robin_arbiter_n: N=%0d outside 2..%0d", N, N_MAX);
  end
  if (MAX_BURST < 1 || MAX_BURST > MAX_BURST_MAX) begin : g_bad_burst
    $error("round_robin_arbiter_n: MAX_BURST=%0d outside 1..%0d", MAX_BURST, MAX_BURST_MAX);
  end

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic            owner_valid_q, owner_valid_d;
  logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;

  logic [N-1:0]    pick;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;

  logic            hold;
  logic [N-1:0]    dec_grants;
  logic [IDXW-1:0] dec_idx;
  logic            dec_valid;

  rr_priority_pick #(.N(N)) u_pick (
    .requests_i (requests),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .found_o    (pick_found)
  );

  // Request/grant contract: a requester holds its bit high until it sees its grant;
  // the grant is consumed on the rising edge where it is asserted, with no back-pressure.
  assign hold = owner_valid_q && requests[owner_q] && (burst_cnt_q < CNTW'(MAX_BURST));

  always_comb begin
    dec_grants = '0;
    dec_idx    = '0;
    dec_valid  = 1'b0;
    if (hold) begin
      dec_grants[owner_q] = 1'b1;
      dec_idx             = owner_q;
      dec_valid           = 1'b1;
    end else if (pick_found) begin
      dec_grants = pick;
      dec_idx    = pick_idx;
      dec_valid  = 1'b1;
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    if (dec_valid) begin
      ptr_d = IDXW'(rr_next_idx(32'(dec_idx), 32'(N)));
      if (hold) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        owner_d       = dec_idx;
        owner_valid_d = 1'b1;
        burst_cnt_d   = CNTW'(1);
      end
    end else begin
      owner_valid_d = 1'b0;
      burst_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

`ifdef ROUND_ROBIN_ARB_OUT_REG_EN
  logic [N-1:0]    grants_q;
  logic [IDXW-1:0] grant_idx_q;
  logic            grant_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grants_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      grants_q      <= dec_grants;
      grant_idx_q   <= dec_idx;
      grant_valid_q <= dec_valid;
    end
  end

  assign grants      = grants_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
`else
  // Gate with reset so outputs drop asynchronously while rst is low.
  assign grants      = rst ? dec_grants : '0;
  assign grant_idx   = rst ? dec_idx    : '0;
  assign grant_valid = rst & dec_valid;
`endif

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed bench for round_robin_arbiter_n: four instances covering N=2/3/4 and burst lengths 1/3/4.
module tb_round_robin_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] req2,  gnt2;  logic [0:0] idx2;  logic vld2;
  logic [2:0] req3,  gnt3;  logic [1:0] idx3;  logic vld3;
  logic [3:0] req4a, gnt4a; logic [1:0] idx4a; logic vld4a;
  logic [3:0] req4b, gnt4b; logic [1:0] idx4b; logic vld4b;

  int n_checks = 0;
  int n_pass   = 0;

  round_robin_arbiter_n #(.N(2), .MAX_BURST(1)) u_n2 (
    .clk(clk), .rst(rst), .requests(req2), .grants(gnt2), .grant_idx(idx2), .grant_valid(vld2));
  round_robin_arbiter_n #(.N(3), .MAX_BURST(1)) u_n3 (
    .clk(clk), .rst(rst), .requests(req3), .grants(gnt3), .grant_idx(idx3), .grant_valid(vld3));
  round_robin_arbiter_n #(.N(4), .MAX_BURST(3)) u_n4b3 (
    .clk(clk), .rst(rst), .requests(req4a), .grants(gnt4a), .grant_idx(idx4a), .grant_valid(vld4a));
  round_robin_arbiter_n #(.N(4), .MAX_BURST(4)) u_n4b4 (
    .clk(clk), .rst(rst), .requests(req4b), .grants(gnt4b), .grant_idx(idx4b), .grant_valid(vld4b));

  // Index of the lowest set bit of a one-hot grant; 0 when none.
  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // With registered outputs the visible grant is the previous cycle's decision.
  task automatic shape(input logic [3:0] cur, inout logic [3:0] prev, output logic [3:0] vis);
`ifdef ROUND_ROBIN_ARB_OUT_REG_EN
    vis  = prev;
    prev = cur;
`else
    vis = cur;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req2 = '0; req3 = '0; req4a = '0; req4b = '0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    req2 = '1; req3 = '1; req4a = '1; req4b = '1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({gnt2, idx2, vld2} !== 4'b0) $display("FAIL reset_n2 got %b want 0000", {gnt2, idx2, vld2});
    else n_pass++;
    n_checks++;
    if ({gnt3, idx3, vld3} !== 6'b0) $display("FAIL reset_n3 got %b want 000000", {gnt3, idx3, vld3});
    else n_pass++;
    n_checks++;
    if ({gnt4a, idx4a, vld4a} !== 7'b0) $display("FAIL reset_n4b3 got %b want 0", {gnt4a, idx4a, vld4a});
    else n_pass++;
    n_checks++;
    if ({gnt4b, idx4b, vld4b} !== 7'b0) $display("FAIL reset_n4b4 got %b want 0", {gnt4b, idx4b, vld4b});
    else n_pass++;
  endtask

  task automatic test_n2_pure_rr();
    logic [1:0] rq [10];
    logic [1:0] gt [10];
    logic [3:0] prev, vis;
    int ei;
    rq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    gt = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    reset_dut();
    prev = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 req2 = rq[k];
      @(negedge clk);
      shape({2'b00, gt[k]}, prev, vis);
      ei = idx_of(vis);
      n_checks++;
      if (gnt2 !== vis[1:0]) $display("FAIL n2_grants cyc %0d got %b want %b", k, gnt2, vis[1:0]);
      else n_pass++;
      n_checks++;
      if ({idx2, vld2} !== {1'(ei), |vis})
        $display("FAIL n2_idx_valid cyc %0d got %b/%b want %0d/%b", k, idx2, vld2, ei, |vis);
      else n_pass++;
    end
  endtask

  task automatic test_n3_wrap();
    logic [2:0] gt [4];
    logic [3:0] prev, vis;
    int ei;
    gt = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset_dut();
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 req3 = 3'b111;
      @(negedge clk);
      shape({1'b0, gt[k]}, prev, vis);
      ei = idx_of(vis);
      n_checks++;
      if (gnt3 !== vis[2:0]) $display("FAIL n3_grants cyc %0d got %b want %b", k, gnt3, vis[2:0]);
      else n_pass++;
      n_checks++;
      if ({idx3, vld3} !== {2'(ei), |vis})
        $display("FAIL n3_idx_valid cyc %0d got %0d/%b want %0d/%b", k, idx3, vld3, ei, |vis);
      else n_pass++;
    end
  endtask

  task automatic test_burst_rotate();
    logic [3:0] gt [8];
    logic [3:0] prev, vis;
    int ei;
    gt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    reset_dut();
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 req4a = 4'b0011;
      @(negedge clk);
      shape(gt[k], prev, vis);
      ei = idx_of(vis);
      n_checks++;
      if (gnt4a !== vis) $display("FAIL burst_grants cyc %0d got %b want %b", k, gnt4a, vis);
      else n_pass++;
      n_checks++;
      if ({idx4a, vld4a} !== {2'(ei), |vis})
        $display("FAIL burst_idx_valid cyc %0d got %0d/%b want %0d/%b", k, idx4a, vld4a, ei, |vis);
      else n_pass++;
    end
  endtask

  task automatic test_early_release();
    logic [3:0] rq [5];
    logic [3:0] gt [5];
    logic [3:0] prev, vis;
    int ei;
    rq = '{4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0001};
    gt = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
    reset_dut();
    prev = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 req4b = rq[k];
      @(negedge clk);
      shape(gt[k], prev, vis);
      ei = idx_of(vis);
      n_checks++;
      if (gnt4b !== vis) $display("FAIL release_grants cyc %0d got %b want %b", k, gnt4b, vis);
      else n_pass++;
      n_checks++;
      if ({idx4b, vld4b} !== {2'(ei), |vis})
        $display("FAIL release_idx_valid cyc %0d got %0d/%b want %0d/%b", k, idx4b, vld4b, ei, |vis);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] gt [4];
    logic [3:0] prev, vis;
    gt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    reset_dut();
    prev = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 req4a = 4'b0011;
      @(negedge clk);
      shape(4'b0001, prev, vis);
      n_checks++;
      if (gnt4a !== vis) $display("FAIL midrst_pre cyc %0d got %b want %b", k, gnt4a, vis);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (gnt4a !== 4'b0001) $display("FAIL midrst_cyc2 got %b want 0001", gnt4a);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({gnt4a, idx4a, vld4a} !== 7'b0) $display("FAIL midrst_async got %b want 0", {gnt4a, idx4a, vld4a});
    else n_pass++;
    req4a = '0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 req4a = 4'b0011;
      @(negedge clk);
      shape(gt[k], prev, vis);
      n_checks++;
      if (gnt4a !== vis) $display("FAIL midrst_post cyc %0d got %b want %b", k, gnt4a, vis);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    req2 = '0; req3 = '0; req4a = '0; req4b = '0;
    reset_dut();
    test_reset();
    test_n2_pure_rr();
    test_n3_wrap();
    test_burst_rotate();
    test_early_release();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_n.md
# round_robin_arbiter_n

Parametrised N-requester round-robin arbiter with optional burst hold: a granted requester may keep the grant for up to MAX_BURST consecutive cycles while it keeps requesting. Priority then rotates to the next index. Successor to the 2-request arbiter. Sits in front of any shared single-port resource (bus, memory port, FIFO write side) and drives one-hot grants plus a binary index for the downstream mux.

## Interface
- N, default 4: number of requesters, 2..32.
- MAX_BURST, default 1: maximum consecutive grants to one requester, 1..255. A value of 1 gives pure round-robin.
- IDXW, localparam: $clog2(N).
- CNTW, localparam: $clog2(MAX_BURST+1).

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- requests  in  N  request vector, bit i = requester i
- grants  out  N  one-hot grant, or all-zero
- grant_idx  out  IDXW  binary index of the granted requester; 0 when grant_valid=0
- grant_valid  out  1  OR of grants

## Operation
- State:
  - ptr (IDXW), the search start index
  - owner (IDXW) and owner_valid (1)
  - burst_cnt (CNTW)
- Reset state: ptr=0, owner=0, owner_valid=0, burst_cnt=0. While rst is low, grants, grant_idx and grant_valid are forced to 0.
- Decision each cycle, combinational:
  - Hold: if owner_valid && requests[owner] && burst_cnt < MAX_BURST, grant owner.
  - Search: otherwise, grant the first set bit of requests, starting at ptr and going upward. The search wraps from N-1 to 0, including for non-power-of-two N.
  - No request: all outputs are 0.
- Update at the clock edge when index g is granted:
  - ptr <= (g+1) mod N.
  - If the grant was a hold: burst_cnt <= burst_cnt+1.
  - If the grant came from the search: owner <= g, owner_valid <= 1, burst_cnt <= 1.
- Update at the clock edge with no grant: owner_valid <= 0 and burst_cnt <= 0. ptr is unchanged.
- Early release: when the owner drops its request, the hold ends immediately. The search runs in the same cycle.
- A search that lands on the previous owner starts a new burst with burst_cnt=1. This only happens when it is the sole requester.
- burst_cnt never exceeds MAX_BURST; there is no wrap-around.
- Requests of other requesters never pre-empt an active hold.
- Out-of-range parameters are caught by an elaboration-time check.

## Timing
- Default: zero-cycle latency. Grants are a combinational function of requests and the registered state.
- State updates on the same rising edge that consumes the grant.
- Requesters hold requests high until granted. A request that drops before it is granted is simply lost; no error is flagged.
- Reset asserted mid-burst: outputs go to 0 asynchronously. After release, arbitration restarts from ptr=0 with no owner.

## Configuration
- ROUND_ROBIN_ARB_OUT_REG_EN defined:
  - grants, grant_idx and grant_valid are registered copies of the combinational decision, giving 1 cycle latency.
  - Their reset value is 0.
  - Internal state updates unchanged, from the combinational decision.
- Not defined: outputs are combinational, as in Timing.

## Structure
- Package rr_arb_pkg holds:
  - limits N_MAX=32 and MAX_BURST_MAX=255
  - a function rr_next_idx(idx, n) implementing (idx+1) mod n
- Sub-module rr_priority_pick: rotating find-first-set.
  - Inputs: requests and ptr.
  - Outputs: one-hot pick, binary index, found flag.
  - Parameter: N.
- The top level holds the hold/burst logic, the state registers and the optional output register.

## Test plan
- N=2, MAX_BURST=1, requests 01 00 10 11 11 00 11 00 11 11 -> grants 01 00 10 01 10 00 01 00 10 01.
- N=3, MAX_BURST=1, requests=111 for 4 cycles -> grants 001,010,100,001; grant_idx 0,1,2,0.
- N=4, MAX_BURST=3, requests=0011 for 8 cycles -> grants 0001 x3, 0010 x3, 0001 x2.
- N=4, MAX_BURST=4, requests 0101,0101,0100 -> grants 0001,0001,0100. Early release: the next search starts at ptr=1.
- N=4, MAX_BURST=3, requests=0011; drive rst low in cycle 2 of a burst -> outputs 0 immediately. After release -> grant 0001 with burst_cnt restarting at 1.
- ROUND_ROBIN_ARB_OUT_REG_EN defined, first scenario -> same grant sequence delayed by one cycle, 00 in the first cycle after reset.
